// File: rtl/link_status_filter.sv
// Synchronises and debounces the four raw link/clock health inputs ahead of the startup reset
// generator, with per-channel loss/glitch counters and sticky loss flags for slow control.
module link_status_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CNT  = 64,
    parameter int unsigned GLITCH_CNT  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               mmcms_locked_i,
    input  logic               gbt_rxready_i,
    input  logic               gbt_rxvalid_i,
    input  logic               gbt_txready_i,
    input  logic               clear_cnts_i,
    output logic [3:0]         good_o,
    output logic               all_good_o,
    output logic               link_up_o,
    output logic               link_down_o,
    output logic [3:0]         loss_sticky_o,
    output logic [4*CNT_W-1:0] loss_cnt_o,
    output logic [4*CNT_W-1:0] glitch_cnt_o
);

    typedef enum logic [1:0] {
        StBad,
        StQualify,
        StGood,
        StHold
    } chan_state_e;

    localparam logic [7:0]       StableLast = 8'(STABLE_CNT);
    localparam logic [7:0]       GlitchLast = 8'(GLITCH_CNT);
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    logic [3:0] raw;
    assign raw = {gbt_txready_i, gbt_rxvalid_i, gbt_rxready_i, mmcms_locked_i};

    for (genvar n = 0; n < 4; n++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        chan_state_e            state_q;
        logic [7:0]             cnt_q;
        logic                   good_q;
        logic                   sticky_q;
        logic [CNT_W-1:0]       loss_q;
        logic [CNT_W-1:0]       glitch_q;
        logic                   loss_ev;
        logic                   glitch_ev;

        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[n]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Events decoded from current state so the counters see them on the transition edge.
        always_comb begin
            loss_ev   = 1'b0;
            glitch_ev = 1'b0;
            if (!s) begin
                if (state_q == StGood && GlitchLast == 8'd1) begin
                    loss_ev = 1'b1;
                end
                if (state_q == StHold && (cnt_q + 8'd1) == GlitchLast) begin
                    loss_ev = 1'b1;
                end
            end else if (state_q == StHold) begin
                glitch_ev = 1'b1;
            end
        end

        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                state_q <= StBad;
                cnt_q   <= 8'd0;
                good_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StBad: begin
                        if (s) begin
                            if (StableLast == 8'd1) begin
                                state_q <= StGood;
                                cnt_q   <= 8'd0;
                                good_q  <= 1'b1;
                            end else begin
                                state_q <= StQualify;
                                cnt_q   <= 8'd1;
                            end
                        end
                    end
                    StQualify: begin
                        if (!s) begin
                            state_q <= StBad;
                            cnt_q   <= 8'd0;
                        end else if ((cnt_q + 8'd1) == StableLast) begin
                            state_q <= StGood;
                            cnt_q   <= 8'd0;
                            good_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    StGood: begin
                        if (!s) begin
                            if (GlitchLast == 8'd1) begin
                                state_q <= StBad;
                                cnt_q   <= 8'd0;
                                good_q  <= 1'b0;
                            end else begin
                                state_q <= StHold;
                                cnt_q   <= 8'd1;
                            end
                        end
                    end
                    StHold: begin
                        if (s) begin
                            state_q <= StGood;
                            cnt_q   <= 8'd0;
                        end else if ((cnt_q + 8'd1) == GlitchLast) begin
                            state_q <= StBad;
                            cnt_q   <= 8'd0;
                            good_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= StBad;
                        cnt_q   <= 8'd0;
                        good_q  <= 1'b0;
                    end
                endcase
            end
        end

        // Clear wins over a coincident event; counters saturate rather than wrap.
        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                loss_q   <= '0;
                glitch_q <= '0;
                sticky_q <= 1'b0;
            end else if (clear_cnts_i) begin
                loss_q   <= '0;
                glitch_q <= '0;
                sticky_q <= 1'b0;
            end else begin
                if (loss_ev) begin
                    sticky_q <= 1'b1;
                    if (loss_q != CntMax) begin
                        loss_q <= loss_q + CntOne;
                    end
                end
                if (glitch_ev && glitch_q != CntMax) begin
                    glitch_q <= glitch_q + CntOne;
                end
            end
        end

        assign good_o[n]                         = good_q;
        assign loss_sticky_o[n]                  = sticky_q;
        assign loss_cnt_o[n*CNT_W +: CNT_W]      = loss_q;
        assign glitch_cnt_o[n*CNT_W +: CNT_W]    = glitch_q;
    end

    logic all_good_q;
    logic all_good_dly_q;
    logic link_up_q;
    logic link_down_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            all_good_q     <= 1'b0;
            all_good_dly_q <= 1'b0;
            link_up_q      <= 1'b0;
            link_down_q    <= 1'b0;
        end else begin
            all_good_q     <= &good_o;
            all_good_dly_q <= all_good_q;
            link_up_q      <= all_good_q & ~all_good_dly_q;
            link_down_q    <= ~all_good_q & all_good_dly_q;
        end
    end

    assign all_good_o  = all_good_q;
    assign link_up_o   = link_up_q;
    assign link_down_o = link_down_q;

endmodule

// File: tb/tb_link_status_filter.sv
// Scoreboard bench for link_status_filter: a run-length reference model predicts every output
// each cycle; a monitor process pops and compares after each clock edge.
module tb_link_status_filter;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 64;
    localparam int unsigned GLITCH = 4;
    localparam int unsigned W      = 8;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           mmcms_locked, gbt_rxready, gbt_rxvalid, gbt_txready;
    logic           clear_cnts;
    logic [3:0]     good;
    logic           all_good, link_up, link_down;
    logic [3:0]     loss_sticky;
    logic [4*W-1:0] loss_cnt, glitch_cnt;

    always #12 clock = ~clock;

    link_status_filter #(
        .SYNC_STAGES(SYNC),
        .STABLE_CNT (STABLE),
        .GLITCH_CNT (GLITCH),
        .CNT_W      (W)
    ) dut (
        .clock_i       (clock),
        .reset_n_i     (reset_n),
        .mmcms_locked_i(mmcms_locked),
        .gbt_rxready_i (gbt_rxready),
        .gbt_rxvalid_i (gbt_rxvalid),
        .gbt_txready_i (gbt_txready),
        .clear_cnts_i  (clear_cnts),
        .good_o        (good),
        .all_good_o    (all_good),
        .link_up_o     (link_up),
        .link_down_o   (link_down),
        .loss_sticky_o (loss_sticky),
        .loss_cnt_o    (loss_cnt),
        .glitch_cnt_o  (glitch_cnt)
    );

    typedef struct packed {
        logic [3:0]     good;
        logic           all_good;
        logic           up;
        logic           down;
        logic [3:0]     sticky;
        logic [4*W-1:0] loss;
        logic [4*W-1:0] glitch;
    } exp_t;

    exp_t exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: raw samples delayed through a queue, then run lengths of highs/lows.
    bit         hist[4][$];
    int         hi_run[4], lo_run[4], loss_n[4], glitch_n[4];
    logic [3:0] m_good, m_sticky;
    logic       m_all, m_all_d, m_up, m_down;

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            hist[n].delete();
            for (int k = 0; k < int'(SYNC); k++) hist[n].push_back(1'b0);
            hi_run[n]   = 0;
            lo_run[n]   = 0;
            loss_n[n]   = 0;
            glitch_n[n] = 0;
        end
        m_good   = '0;
        m_sticky = '0;
        m_all    = 1'b0;
        m_all_d  = 1'b0;
        m_up     = 1'b0;
        m_down   = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] raw, input logic clr);
        logic [3:0] old_good;
        exp_t       e;
        old_good = m_good;
        for (int n = 0; n < 4; n++) begin
            bit s;
            bit loss_ev;
            bit glitch_ev;
            s = hist[n].pop_front();
            hist[n].push_back(raw[n]);
            loss_ev   = 1'b0;
            glitch_ev = 1'b0;
            if (!m_good[n]) begin
                hi_run[n] = s ? hi_run[n] + 1 : 0;
                if (hi_run[n] >= int'(STABLE)) begin
                    m_good[n] = 1'b1;
                    lo_run[n] = 0;
                end
            end else if (!s) begin
                lo_run[n]++;
                if (lo_run[n] >= int'(GLITCH)) begin
                    m_good[n] = 1'b0;
                    hi_run[n] = 0;
                    loss_ev   = 1'b1;
                end
            end else begin
                if (lo_run[n] > 0) glitch_ev = 1'b1;
                lo_run[n] = 0;
            end
            if (clr) begin
                loss_n[n]   = 0;
                glitch_n[n] = 0;
                m_sticky[n] = 1'b0;
            end else begin
                if (loss_ev) begin
                    m_sticky[n] = 1'b1;
                    if (loss_n[n] < (1 << W) - 1) loss_n[n]++;
                end
                if (glitch_ev && glitch_n[n] < (1 << W) - 1) glitch_n[n]++;
            end
        end
        m_up    = m_all & ~m_all_d;
        m_down  = ~m_all & m_all_d;
        m_all_d = m_all;
        m_all   = &old_good;
        e.good     = m_good;
        e.all_good = m_all;
        e.up       = m_up;
        e.down     = m_down;
        e.sticky   = m_sticky;
        for (int n = 0; n < 4; n++) begin
            e.loss[n*W +: W]   = W'(loss_n[n]);
            e.glitch[n*W +: W] = W'(glitch_n[n]);
        end
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%h model=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".good"}, 32'(good), 32'd0);
        check({tag, ".all_good"}, 32'(all_good), 32'd0);
        check({tag, ".link_up"}, 32'(link_up), 32'd0);
        check({tag, ".link_down"}, 32'(link_down), 32'd0);
        check({tag, ".sticky"}, 32'(loss_sticky), 32'd0);
        check({tag, ".loss"}, loss_cnt, 32'd0);
        check({tag, ".glitch"}, glitch_cnt, 32'd0);
    endtask

    // Monitor: one expectation per clock edge while stimulus is active.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("good", 32'(good), 32'(e.good));
                check("all_good", 32'(all_good), 32'(e.all_good));
                check("link_up", 32'(link_up), 32'(e.up));
                check("link_down", 32'(link_down), 32'(e.down));
                check("sticky", 32'(loss_sticky), 32'(e.sticky));
                check("loss_cnt", loss_cnt, e.loss);
                check("glitch_cnt", glitch_cnt, e.glitch);
            end
        end
    end

    task automatic apply(input logic [3:0] raw, input logic clr);
        {gbt_txready, gbt_rxvalid, gbt_rxready, mmcms_locked} = raw;
        clear_cnts = clr;
        model_step(raw, clr);
    endtask

    task automatic drive(input logic [3:0] raw, input logic clr);
        @(negedge clock);
        apply(raw, clr);
    endtask

    task automatic assert_reset(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        repeat (3) @(posedge clock);
    endtask

    task automatic release_reset(input logic [3:0] raw);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        apply(raw, 1'b0);
    endtask

    initial begin
        logic [3:0] val;
        int         rem[4];
        reset_n    = 1'b0;
        {gbt_txready, gbt_rxvalid, gbt_rxready, mmcms_locked} = 4'h0;
        clear_cnts = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");

        // All inputs high from reset release.
        release_reset(4'hF);
        repeat (79) drive(4'hF, 1'b0);

        // Absorbed 3-cycle dropout on rxvalid.
        repeat (3) drive(4'b1011, 1'b0);
        repeat (20) drive(4'hF, 1'b0);

        // 4-cycle dropout on txready is a loss; then requalify.
        repeat (4) drive(4'b0111, 1'b0);
        repeat (80) drive(4'hF, 1'b0);

        // Lose mmcm, then drop it once at qualification count 63.
        repeat (10) drive(4'b1110, 1'b0);
        repeat (63) drive(4'hF, 1'b0);
        drive(4'b1110, 1'b0);
        repeat (70) drive(4'hF, 1'b0);

        // 300 losses on rxready to saturate its counter.
        for (int i = 0; i < 300; i++) begin
            repeat (70) drive(4'hF, 1'b0);
            repeat (5) drive(4'b1101, 1'b0);
        end
        repeat (70) drive(4'hF, 1'b0);
        // Clear lands on the same edge as the loss event.
        for (int i = 0; i < int'(SYNC) + 4; i++) begin
            drive(4'b1101, (i == int'(SYNC) + 3) ? 1'b1 : 1'b0);
        end
        repeat (80) drive(4'hF, 1'b0);

        // Reset while channel 3 sits in HOLD, then requalify.
        repeat (int'(SYNC) + 2) drive(4'b0111, 1'b0);
        assert_reset("reset_in_hold");
        release_reset(4'hF);
        repeat (80) drive(4'hF, 1'b0);

        // Randomised dropouts with occasional clears.
        val = 4'hF;
        for (int n = 0; n < 4; n++) rem[n] = $urandom_range(5, 100);
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 4; n++) begin
                if (rem[n] == 0) begin
                    val[n] = ~val[n];
                    if (val[n]) rem[n] = $urandom_range(10, 120);
                    else if ($urandom_range(0, 3) == 0) rem[n] = $urandom_range(5, 12);
                    else rem[n] = $urandom_range(1, 5);
                end
                rem[n]--;
            end
            drive(val, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        repeat (2) @(posedge clock);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
